// File: rtl/play_judge.sv
// play_judge: judges key hits against chart notes across LANES lanes, keeps
// session score/combo, and commits per-user bests to a small high-score table.
module play_judge #(
  parameter int unsigned LANES       = 7,
  parameter int unsigned CLOCK_BITS  = 32,
  parameter int unsigned SCORE_BITS  = 21,
  parameter int unsigned USER_BITS   = 2,
  parameter int unsigned WIN_PERFECT = 4,
  parameter int unsigned WIN_GOOD    = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [USER_BITS-1:0]     user,
  input  logic [1:0]               mod,
  input  logic [CLOCK_BITS-1:0]    system_clock,
  input  logic                     note_valid,
  input  logic [$clog2(LANES)-1:0] note_lane,
  input  logic [CLOCK_BITS-1:0]    note_time,
  output logic                     note_ready,
  input  logic [LANES-1:0]         hit_key,
  input  logic                     song_done,
  output logic                     judge_valid,
  output logic [1:0]               judge_grade,
  output logic [SCORE_BITS-1:0]    score,
  output logic [SCORE_BITS-1:0]    combo,
  output logic [SCORE_BITS-1:0]    max_combo,
  output logic [SCORE_BITS-1:0]    hs_score,
  output logic [SCORE_BITS-1:0]    hs_combo,
  output logic                     finished
);

  localparam int unsigned LANE_W       = $clog2(LANES);
  localparam int unsigned USERS        = 1 << USER_BITS;
  localparam int unsigned SUM_W        = SCORE_BITS + 1;
  localparam int unsigned BASE_PERFECT = 300;
  localparam int unsigned BASE_GOOD    = 100;

  localparam logic [1:0] GR_MISS    = 2'b00;
  localparam logic [1:0] GR_GOOD    = 2'b01;
  localparam logic [1:0] GR_PERFECT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_PENDING,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t                  state;
  logic [LANES-1:0]        hit_q;
  logic [LANE_W-1:0]       pend_lane;
  logic [CLOCK_BITS-1:0]   pend_time;
  logic                    done_flag;

  logic [SCORE_BITS-1:0]   hs_s_tab [USERS];
  logic [SCORE_BITS-1:0]   hs_c_tab [USERS];

  logic [LANES-1:0]        key_edge;
  logic                    lane_edge;
  logic [CLOCK_BITS-1:0]   p_win;
  logic [CLOCK_BITS-1:0]   g_win;
  logic [CLOCK_BITS-1:0]   d_raw;
  logic                    d_neg;
  logic [CLOCK_BITS-1:0]   d_abs;
  logic                    too_early;
  logic                    too_late;
  logic                    judge_c;
  logic [1:0]              grade_c;
  logic [SUM_W-1:0]        base_c;
  logic [SUM_W-1:0]        sum_c;
  logic [SCORE_BITS-1:0]   score_hit;
  logic [SCORE_BITS-1:0]   combo_hit;
  logic [SCORE_BITS-1:0]   max_hit;
  logic [SCORE_BITS-1:0]   hs_s_new;
  logic [SCORE_BITS-1:0]   hs_c_new;

  // Rising edges of the raw key levels.
  assign key_edge = hit_key & ~hit_q;

  // Select the edge of the lane the pending note sits on.
  always_comb begin
    lane_edge = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (pend_lane == LANE_W'(i)) lane_edge = key_edge[i];
    end
  end

  // Timing windows scaled by the speed mod (sampled every cycle).
  always_comb begin
    case (mod)
      2'b10: begin
        p_win = CLOCK_BITS'(WIN_PERFECT) << 1;
        g_win = CLOCK_BITS'(WIN_GOOD) << 1;
      end
      2'b11: begin
        p_win = CLOCK_BITS'(WIN_PERFECT) >> 1;
        g_win = CLOCK_BITS'(WIN_GOOD) >> 1;
      end
      default: begin
        p_win = CLOCK_BITS'(WIN_PERFECT);
        g_win = CLOCK_BITS'(WIN_GOOD);
      end
    endcase
  end

  // Signed hit offset (wraps modulo 2^CLOCK_BITS) and its magnitude.
  assign d_raw     = system_clock - pend_time;
  assign d_neg     = d_raw[CLOCK_BITS-1];
  assign d_abs     = d_neg ? (~d_raw + CLOCK_BITS'(1)) : d_raw;
  assign too_early = d_neg && (d_abs > g_win);
  assign too_late  = !d_neg && (d_abs > g_win);

  // Grade decision for the pending note in this cycle.
  always_comb begin
    judge_c = 1'b0;
    grade_c = GR_MISS;
    if (state == S_PENDING) begin
      if (too_late) begin
        judge_c = 1'b1;
        grade_c = GR_MISS;
      end else if (lane_edge && !too_early) begin
        judge_c = 1'b1;
        grade_c = (d_abs <= p_win) ? GR_PERFECT : GR_GOOD;
      end
    end
  end

  // Saturating score/combo update for a hit.
  always_comb begin
    base_c    = (grade_c == GR_PERFECT) ? SUM_W'(BASE_PERFECT) : SUM_W'(BASE_GOOD);
    sum_c     = {1'b0, score} + base_c + {1'b0, combo >> 4};
    score_hit = sum_c[SCORE_BITS] ? '1 : sum_c[SCORE_BITS-1:0];
    combo_hit = (&combo) ? combo : combo + SCORE_BITS'(1);
    max_hit   = (combo_hit > max_combo) ? combo_hit : max_combo;
  end

  // Candidate high-score entries for the selected user.
  assign hs_s_new = (score > hs_s_tab[user]) ? score : hs_s_tab[user];
  assign hs_c_new = (max_combo > hs_c_tab[user]) ? max_combo : hs_c_tab[user];

  assign hs_score = hs_s_tab[user];
  assign hs_combo = hs_c_tab[user];

  // Session FSM, scoring registers and high-score table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      hit_q       <= '0;
      pend_lane   <= '0;
      pend_time   <= '0;
      done_flag   <= 1'b0;
      note_ready  <= 1'b0;
      judge_valid <= 1'b0;
      judge_grade <= GR_MISS;
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
      finished    <= 1'b0;
      for (int unsigned i = 0; i < USERS; i++) begin
        hs_s_tab[i] <= '0;
        hs_c_tab[i] <= '0;
      end
    end else begin
      hit_q       <= hit_key;
      judge_valid <= 1'b0;
      if (!en) begin
        state       <= S_IDLE;
        pend_lane   <= '0;
        pend_time   <= '0;
        done_flag   <= 1'b0;
        note_ready  <= 1'b0;
        judge_grade <= GR_MISS;
        score       <= '0;
        combo       <= '0;
        max_combo   <= '0;
        finished    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state      <= S_ARMED;
            note_ready <= 1'b1;
          end
          S_ARMED: begin
            if (note_valid && note_ready) begin
              // An accepted note is never dropped; a coincident song end is remembered.
              pend_lane  <= note_lane;
              pend_time  <= note_time;
              done_flag  <= song_done;
              note_ready <= 1'b0;
              state      <= S_PENDING;
            end else if (song_done) begin
              note_ready <= 1'b0;
              state      <= S_COMMIT;
            end
          end
          S_PENDING: begin
            if (song_done) done_flag <= 1'b1;
            if (judge_c) begin
              judge_valid <= 1'b1;
              judge_grade <= grade_c;
              if (grade_c == GR_MISS) begin
                combo <= '0;
              end else begin
                score     <= score_hit;
                combo     <= combo_hit;
                max_combo <= max_hit;
              end
              if (done_flag || song_done) begin
                done_flag <= 1'b0;
                state     <= S_COMMIT;
              end else begin
                note_ready <= 1'b1;
                state      <= S_ARMED;
              end
            end
          end
          S_COMMIT: begin
            hs_s_tab[user] <= hs_s_new;
            hs_c_tab[user] <= hs_c_new;
            finished       <= 1'b1;
            state          <= S_DONE;
          end
          S_DONE: begin
            finished <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_play_judge.sv
// Directed bench for play_judge: table-driven note vectors plus hand sequences.
module tb_play_judge;

  localparam int unsigned LANES = 7;
  localparam int unsigned CB    = 32;
  localparam int unsigned SB    = 21;
  localparam int unsigned UB    = 2;

  localparam logic [1:0] MISS = 2'b00;
  localparam logic [1:0] GOOD = 2'b01;
  localparam logic [1:0] PERF = 2'b10;

  typedef struct packed {
    logic [1:0]  md;
    logic [2:0]  lane;
    logic [31:0] nt;
    logic        press;
    logic [31:0] t;
    logic [1:0]  grade;
    logic [31:0] sc;
    logic [31:0] cb;
    logic [31:0] mx;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [UB-1:0]  user;
  logic [1:0]     mod;
  logic [CB-1:0]  system_clock;
  logic           note_valid;
  logic [2:0]     note_lane;
  logic [CB-1:0]  note_time;
  logic           note_ready;
  logic [LANES-1:0] hit_key;
  logic           song_done;
  logic           judge_valid;
  logic [1:0]     judge_grade;
  logic [SB-1:0]  score;
  logic [SB-1:0]  combo;
  logic [SB-1:0]  max_combo;
  logic [SB-1:0]  hs_score;
  logic [SB-1:0]  hs_combo;
  logic           finished;

  int n_vec = 0;
  int n_bad = 0;

  vec_t va [10];
  vec_t vb [21];

  play_judge #(
    .LANES(LANES), .CLOCK_BITS(CB), .SCORE_BITS(SB), .USER_BITS(UB),
    .WIN_PERFECT(4), .WIN_GOOD(12)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .user(user), .mod(mod),
    .system_clock(system_clock), .note_valid(note_valid), .note_lane(note_lane),
    .note_time(note_time), .note_ready(note_ready), .hit_key(hit_key),
    .song_done(song_done), .judge_valid(judge_valid), .judge_grade(judge_grade),
    .score(score), .combo(combo), .max_combo(max_combo),
    .hs_score(hs_score), .hs_combo(hs_combo), .finished(finished)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [1:0] md, input logic [2:0] lane,
                              input int nt, input logic press, input int t,
                              input logic [1:0] grade, input int sc, input int cb,
                              input int mx);
    vec_t v;
    v.md = md; v.lane = lane; v.nt = 32'(nt); v.press = press; v.t = 32'(t);
    v.grade = grade; v.sc = 32'(sc); v.cb = 32'(cb); v.mx = 32'(mx);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 20 && note_ready !== 1'b1; i++) @(negedge clk);
    chk({tag, "_ready"}, 32'(note_ready), 32'd1);
  endtask

  task automatic chk_judge(input string tag, input logic [1:0] g, input int sc,
                           input int cb, input int mx);
    chk({tag, "_valid"}, 32'(judge_valid), 32'd1);
    chk({tag, "_grade"}, 32'(judge_grade), 32'(g));
    chk({tag, "_score"}, 32'(score), 32'(sc));
    chk({tag, "_combo"}, 32'(combo), 32'(cb));
    chk({tag, "_max"},   32'(max_combo), 32'(mx));
  endtask

  task automatic accept(input logic [1:0] md, input logic [2:0] lane, input int nt,
                        input string tag);
    wait_ready(tag);
    mod = md; note_valid = 1'b1; note_lane = lane; note_time = 32'(nt);
    system_clock = '0;
    @(negedge clk);
    note_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    hit_key = '0;
    accept(v.md, v.lane, int'(v.nt), tag);
    system_clock = v.t;
    if (v.press) hit_key[v.lane] = 1'b1;
    @(negedge clk);
    hit_key = '0;
    chk_judge(tag, v.grade, int'(v.sc), int'(v.cb), int'(v.mx));
    chk({tag, "_rdy_after"}, 32'(note_ready), 32'd1);
  endtask

  task automatic session_off(input string tag);
    en = 1'b0;
    @(negedge clk);
    chk({tag, "_score0"}, 32'(score), 32'd0);
    chk({tag, "_combo0"}, 32'(combo), 32'd0);
    chk({tag, "_max0"},   32'(max_combo), 32'd0);
    chk({tag, "_fin0"},   32'(finished), 32'd0);
    chk({tag, "_rdy0"},   32'(note_ready), 32'd0);
    en = 1'b1;
  endtask

  initial begin
    // Session A: window scaling and boundaries (score accumulates from 0).
    va[0] = mk(2'b11, 3'd1, 300, 1'b1, 305, GOOD, 100,  1, 1);
    va[1] = mk(2'b10, 3'd4, 400, 1'b1, 380, GOOD, 200,  2, 2);
    va[2] = mk(2'b10, 3'd5, 450, 1'b1, 442, PERF, 500,  3, 3);
    va[3] = mk(2'b00, 3'd0, 600, 1'b1, 604, PERF, 800,  4, 4);
    va[4] = mk(2'b01, 3'd6, 650, 1'b1, 655, GOOD, 900,  5, 5);
    va[5] = mk(2'b00, 3'd2, 700, 1'b1, 688, GOOD, 1000, 6, 6);
    va[6] = mk(2'b00, 3'd3, 750, 1'b1, 762, GOOD, 1100, 7, 7);
    va[7] = mk(2'b11, 3'd1, 800, 1'b1, 797, GOOD, 1200, 8, 8);
    va[8] = mk(2'b11, 3'd2, 850, 1'b0, 857, MISS, 1200, 0, 8);
    va[9] = mk(2'b10, 3'd0, 900, 1'b1, 924, GOOD, 1300, 1, 8);

    // Session B: 20 perfects (hits 17..20 earn the combo bonus of 1) then a timeout.
    vb[0] = mk(2'b00, 3'd2, 100, 1'b1, 102, PERF, 300, 1, 1);
    for (int k = 1; k < 16; k++)
      vb[k] = mk(2'b00, 3'(k % 7), 1000 + 20 * k, 1'b1, 1000 + 20 * k, PERF,
                 300 * (k + 1), k + 1, k + 1);
    vb[16] = mk(2'b00, 3'(16 % 7), 1320, 1'b1, 1320, PERF, 5101, 17, 17);
    vb[17] = mk(2'b00, 3'(17 % 7), 1340, 1'b1, 1340, PERF, 5402, 18, 18);
    vb[18] = mk(2'b00, 3'(18 % 7), 1360, 1'b1, 1360, PERF, 5703, 19, 19);
    vb[19] = mk(2'b00, 3'(19 % 7), 1380, 1'b1, 1380, PERF, 6004, 20, 20);
    vb[20] = mk(2'b00, 3'd0, 200, 1'b0, 213, MISS, 6004, 0, 20);

    rst = 1'b1; en = 1'b0; user = '0; mod = 2'b00; system_clock = '0;
    note_valid = 1'b0; note_lane = '0; note_time = '0; hit_key = '0; song_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_score",  32'(score), 32'd0);
    chk("rst_combo",  32'(combo), 32'd0);
    chk("rst_max",    32'(max_combo), 32'd0);
    chk("rst_jv",     32'(judge_valid), 32'd0);
    chk("rst_ready",  32'(note_ready), 32'd0);
    chk("rst_fin",    32'(finished), 32'd0);
    chk("rst_hs",     32'(hs_score), 32'd0);
    rst = 1'b0; en = 1'b1;

    // Session A
    for (int i = 0; i < 10; i++) run_vec(va[i], $sformatf("a%0d", i));

    // Early edge ignored, wrong lane ignored, then a perfect on lane 3.
    accept(2'b00, 3'd3, 500, "seq1");
    system_clock = 32'd487; hit_key = 7'b0001000;
    @(negedge clk);
    chk("seq1_early_ignored", 32'(judge_valid), 32'd0);
    system_clock = 32'd488; hit_key = '0;
    @(negedge clk);
    chk("seq1_idle_cycle", 32'(judge_valid), 32'd0);
    system_clock = 32'd499; hit_key = 7'b1000000;
    @(negedge clk);
    chk("seq1_wrong_lane", 32'(judge_valid), 32'd0);
    system_clock = 32'd496; hit_key = '0;
    @(negedge clk);
    system_clock = 32'd497; hit_key = 7'b0001000;
    @(negedge clk);
    hit_key = '0;
    chk_judge("seq1_hit", PERF, 1600, 2, 8);

    // Key pressed during the accept cycle does not count for the new note.
    wait_ready("seq2");
    mod = 2'b00; note_valid = 1'b1; note_lane = 3'd0; note_time = 32'd1000;
    system_clock = 32'd1000; hit_key = 7'b0000001;
    @(negedge clk);
    note_valid = 1'b0;
    @(negedge clk);
    chk("seq2_held_key", 32'(judge_valid), 32'd0);
    hit_key = '0;
    @(negedge clk);
    system_clock = 32'd1001; hit_key = 7'b0000001;
    @(negedge clk);
    hit_key = '0;
    chk_judge("seq2_hit", PERF, 1900, 3, 8);

    session_off("offA");

    // Session B for user 1, then commit.
    user = 2'd1;
    for (int i = 0; i < 21; i++) run_vec(vb[i], $sformatf("b%0d", i));
    song_done = 1'b1;
    @(negedge clk);
    song_done = 1'b0;
    chk("b_commit_fin", 32'(finished), 32'd0);
    @(negedge clk);
    chk("b_done_fin",   32'(finished), 32'd1);
    chk("b_hs_score",   32'(hs_score), 32'd6004);
    chk("b_hs_combo",   32'(hs_combo), 32'd20);
    chk("b_score_hold", 32'(score), 32'd6004);
    user = 2'd0;
    #1;
    chk("b_hs_user0", 32'(hs_score), 32'd0);
    user = 2'd2;
    #1;
    chk("b_hs_user2", 32'(hs_combo), 32'd0);
    user = 2'd1;
    @(negedge clk);
    chk("b_fin_held", 32'(finished), 32'd1);

    session_off("offB");
    chk("offB_hs_kept", 32'(hs_score), 32'd6004);

    // Session C: song_done while pending; note judged, then commit instead of arming.
    accept(2'b00, 3'd2, 100, "c");
    system_clock = 32'd50; song_done = 1'b1;
    @(negedge clk);
    song_done = 1'b0;
    chk("c_no_judge", 32'(judge_valid), 32'd0);
    system_clock = 32'd100; hit_key = 7'b0000100;
    @(negedge clk);
    hit_key = '0;
    chk_judge("c_hit", PERF, 300, 1, 1);
    chk("c_no_rearm", 32'(note_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("c_fin",      32'(finished), 32'd1);
    chk("c_hs_score", 32'(hs_score), 32'd6004);
    chk("c_hs_combo", 32'(hs_combo), 32'd20);

    session_off("offC");
    chk("offC_hs_kept", 32'(hs_score), 32'd6004);

    // Full reset wipes the table.
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_hs_score", 32'(hs_score), 32'd0);
    chk("rst2_hs_combo", 32'(hs_combo), 32'd0);
    chk("rst2_score",    32'(score), 32'd0);
    chk("rst2_fin",      32'(finished), 32'd0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/play_judge.md
Name: play_judge

Overview:
Parametrised successor to the single-lane play-mode scorer. It judges player key hits against a stream of chart notes across LANES lanes, using timing windows that scale with the speed mod. It keeps session combo, max combo and saturating score, and commits per-user best results into an on-chip high-score table when the song ends. It sits between the chart/song sequencer (note producer) and the scoreboard/tube display (consumer of score, combo and high-score outputs).

Parameters:
LANES, 7, number of note keys/lanes (>=2)
CLOCK_BITS, 32, width of system_clock and note timestamps
SCORE_BITS, 21, width of score, combo and high-score fields
USER_BITS, 2, high-score table holds 2^USER_BITS users
WIN_PERFECT, 4, perfect window half-width in system_clock ticks at mod 00/01
WIN_GOOD, 12, good window half-width in ticks at mod 00/01 (WIN_GOOD > WIN_PERFECT)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  session active; low clears session state
user  in  USER_BITS  high-score table index
mod  in  2  00/01 normal, 10 half-time, 11 double-time
system_clock  in  CLOCK_BITS  free-running timebase
note_valid  in  1  chart note offered
note_lane  in  $clog2(LANES)  lane of offered note
note_time  in  CLOCK_BITS  target hit time
note_ready  out  1  note accepted when note_valid && note_ready
hit_key  in  LANES  raw key levels, edge-detected internally
song_done  in  1  one-cycle pulse: chart exhausted
judge_valid  out  1  one-cycle pulse per judged note
judge_grade  out  2  00 miss, 01 good, 10 perfect
score  out  SCORE_BITS  session score
combo  out  SCORE_BITS  current combo
max_combo  out  SCORE_BITS  session max combo
hs_score  out  SCORE_BITS  best score of `user` (combinational read)
hs_combo  out  SCORE_BITS  best max combo of `user` (combinational read)
finished  out  1  high while in DONE

Behaviour:
- Reset is synchronous and active-high. rst=1 clears everything: all outputs 0, FSM to IDLE, hit_key history 0, entire high-score table 0. en=0 clears session state (score, combo, max_combo, pending note, FSM to IDLE) and leaves the table intact.
- FSM states:
  - IDLE: entered on rst or en=0; goes to ARMED when en=1.
  - ARMED: note_ready=1; on handshake, registers lane/time and goes to PENDING.
  - PENDING: note_ready=0.
  - COMMIT: one cycle.
  - DONE: finished=1; held until en=0.
- Edge detection: hit_q <= hit_key; edge = hit_key & ~hit_q. Edges are evaluated only in PENDING and only on the registered note's lane; edges on other lanes are ignored.
- Window scaling:
  - mod 10: P=WIN_PERFECT<<1, G=WIN_GOOD<<1
  - mod 11: P=WIN_PERFECT>>1, G=WIN_GOOD>>1
  - otherwise unscaled
  - mod is sampled every cycle.
- d = system_clock - note_time, computed modulo 2^CLOCK_BITS and interpreted signed; |d| is correct while |d| < 2^(CLOCK_BITS-1).
- In PENDING, with a lane edge:
  - d < -G: ignored (too early), no judge.
  - |d| <= P: perfect.
  - |d| <= G: good.
- In PENDING with no edge and d > G: miss (timeout).
- Judge latency: the grade is decided in the edge/timeout cycle. judge_valid, judge_grade, score, combo and max_combo update on the next clock edge, and the FSM returns to ARMED on that same edge. A new note is accepted no earlier than one cycle after judge_valid.
- Scoring, on a hit:
  - score += base + (combo_before >> 4), with base = 300 for perfect, 100 for good.
  - combo += 1; max_combo = max(max_combo, combo_new).
  - score and combo saturate at all-ones.
- On a miss: combo = 0, score unchanged.
- song_done:
  - In ARMED: go to COMMIT.
  - In PENDING: set done_flag; the pending note is judged normally, then go to COMMIT instead of ARMED.
  - In IDLE or DONE: ignored.
- COMMIT: hs_score[user] = max(hs_score[user], score); hs_combo[user] = max(hs_combo[user], max_combo). Uses `user` sampled in this cycle. Next state is DONE.
- Edge and song_done in the same cycle: the edge is judged first.
- note_valid and an edge in the same accept cycle: the edge does not apply to the new note.

Test Plan:
- mod=00, note lane 2 @100; hit lane 2 rising at system_clock 102 -> judge_valid one cycle later, grade 10, score 300, combo 1.
- 20 consecutive perfects -> hits 17..20 each add 301; score 6004, combo 20, max_combo 20.
- Note @200, no hit; system_clock reaches 213 -> grade 00, combo 0, max_combo retained, note_ready back to 1 the next cycle.
- mod=11: hit at d=+5 -> good (+100). mod=10: hit at d=-20 -> good; hit at d=-8 -> perfect.
- Note @500: lane-3 edge at 487 ignored (no judge_valid); wrong-lane edge at 499 ignored; correct edge at 497 -> perfect.
- user=1: session score 6004, then song_done -> hs_score=6004, finished=1. Toggle en, second session 300 -> hs_score stays 6004. en toggling keeps the table; rst=1 -> hs_score 0.
